add2_sweep_ctrl: RTL and testbench

Sequential stimulus-and-check stage placed directly upstream of the `add2_bits` 2-bit adder. After a `start` pulse it drives all 16 operand words onto the adder input `a[3:0]`, holding each word for a fixed number of clock cycles. On the last cycle of each hold it samples the adder's 3-bit sum `s[2:0]` and compares it against `a[3:2] + a[1:0]`. It accumulates an error count and a running total of sampled sums, then reports completion and pass/fail.

---
 rtl/add2_pkg.sv | 16 +
 rtl/add2_bits.sv | 11 +
 rtl/add2_sweep_top.sv | 40 ++++
 rtl/add2_sweep_ctrl.sv | 92 +++++++++
 tb/tb_add2_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/add2_pkg.sv
// Shared types and widths for the add2 adder sweep controller and its bench wrapper.
package add2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        FINISH
    } sweep_state_t;

    localparam int NUM_VECTORS = 16;
    localparam int OPW         = 2;
    localparam int SUMW        = 3;
    localparam int ERRW        = 5;
    localparam int TOTW        = 6;

endpackage

// File: rtl/add2_bits.sv
// Combinational 2-bit adder under test: s = a[3:2] + a[1:0].
module add2_bits
    import add2_pkg::*;
(
    input  logic [2*OPW-1:0] a,
    output logic [SUMW-1:0]  s
);

    assign s = {1'b0, a[3:2]} + {1'b0, a[1:0]};

endmodule

// File: rtl/add2_sweep_top.sv
// Bench wrapper pairing the sweep controller with the real 2-bit adder.
module add2_sweep_top
    import add2_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [2*OPW-1:0]  a,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERRW-1:0]   err_count,
    output logic [TOTW-1:0]   sum_total
);

    logic [SUMW-1:0] s;

    add2_bits u_adder (
        .a (a),
        .s (s)
    );

    add2_sweep_ctrl #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s         (s),
        .a         (a),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .sum_total (sum_total)
    );

endmodule

// File: rtl/add2_sweep_ctrl.sv
// Drives all 16 operand words into add2_bits, holding each HOLD_CYCLES cycles,
// samples and checks the returned sum, and reports error count, sum total and pass.
module add2_sweep_ctrl
    import add2_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SUMW-1:0]   s,
    output logic [2*OPW-1:0]  a,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERRW-1:0]   err_count,
    output logic [TOTW-1:0]   sum_total
);

    localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST_CNT  = CW'(HOLD_CYCLES - 1);
    localparam logic [2*OPW-1:0] LAST_WORD = (2*OPW)'(NUM_VECTORS - 1);

    sweep_state_t   state;
    logic [CW-1:0]  cnt;
    logic [SUMW-1:0] golden;
    logic           mismatch;
    logic [ERRW-1:0] err_next;
    logic           accept;

    assign golden   = {1'b0, a[3:2]} + {1'b0, a[1:0]};
    assign mismatch = (s != golden);
    assign err_next = err_count + ERRW'(mismatch);

    // FINISH exits to IDLE on the same edge a new start may be taken, so both accept it.
    assign accept = start && (state == IDLE || state == FINISH);

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            sum_total <= '0;
        end else if (accept) begin
            state     <= DRIVE;
            cnt       <= '0;
            a         <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            sum_total <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                end
                DRIVE: begin
                    if (cnt == LAST_CNT) begin
                        sum_total <= sum_total + TOTW'(s);
                        err_count <= err_next;
                        if (a == LAST_WORD) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            a   <= a + (2*OPW)'(1);
                            cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add2_sweep_ctrl.sv
// Directed bench for add2_sweep_ctrl: three stand-alone controllers (H=2,4,1) with a
// bench-driven sum, plus the wrapper with the real adder, all checked against a model.
module tb_add2_sweep_ctrl;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_v [NI];
    int   mode    [NI];      // 0: correct adder, 1: sum stuck at 0, 2: sum stuck at 7

    logic [3:0] a_o   [NI];
    logic       busy_o[NI];
    logic       done_o[NI];
    logic       pass_o[NI];
    logic [4:0] err_o [NI];
    logic [5:0] tot_o [NI];
    logic [2:0] s_in  [3];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic int hold_of(input int idx);
        case (idx)
            0: return 2;
            1: return 4;
            2: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int golden_of(input int k);
        return (k / 4) + (k % 4);
    endfunction

    function automatic int s_of(input int md, input int k);
        case (md)
            1: return 0;
            2: return 7;
            default: return golden_of(k);
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_sdrv
        assign s_in[g] = 3'(s_of(mode[g], int'(a_o[g])));
    end

    add2_sweep_ctrl #(.HOLD_CYCLES(2)) dut_h2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .s(s_in[0]), .a(a_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_count(err_o[0]), .sum_total(tot_o[0])
    );

    add2_sweep_ctrl #(.HOLD_CYCLES(4)) dut_h4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .s(s_in[1]), .a(a_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_count(err_o[1]), .sum_total(tot_o[1])
    );

    add2_sweep_ctrl #(.HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .s(s_in[2]), .a(a_o[2]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
        .err_count(err_o[2]), .sum_total(tot_o[2])
    );

    add2_sweep_top #(.HOLD_CYCLES(2)) dut_top (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a_o[3]),
        .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]),
        .err_count(err_o[3]), .sum_total(tot_o[3])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: a sweep is described only by cycles elapsed since its accepted start.
    int cyc = 0;
    bit cmp_en = 1'b0;
    bit valid [NI];
    int n     [NI];
    int e0    [NI];
    int md_r  [NI];
    bit seen  [NI];
    int lat   [NI];
    int dcnt  [NI];

    function automatic void model_out(input int h, input int md, input bit v, input int nn,
                                      output int ea, output int eb, output int ed,
                                      output int ep, output int ee, output int es);
        int smp, err, tot;
        err = 0;
        tot = 0;
        if (!v) begin
            ea = 0; eb = 0; ed = 0; ep = 0; ee = 0; es = 0;
            return;
        end
        smp = nn / h;
        if (smp > 16) smp = 16;
        for (int k = 0; k < smp; k++) begin
            if (s_of(md, k) != golden_of(k)) err++;
            tot += s_of(md, k);
        end
        ea = (nn < 16 * h) ? nn / h : 15;
        eb = (nn < 16 * h) ? 1 : 0;
        ed = (nn == 16 * h) ? 1 : 0;
        ep = (nn >= 16 * h && err == 0) ? 1 : 0;
        ee = err;
        es = tot % 64;
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                valid[i] = 1'b0;
                cmp_en   = 1'b1;
            end else if (start_v[i] && (!valid[i] || n[i] >= 16 * hold_of(i))) begin
                valid[i] = 1'b1;
                n[i]     = 0;
                e0[i]    = cyc;
                md_r[i]  = (i == 3) ? 0 : mode[i];
                seen[i]  = 1'b0;
                dcnt[i]  = 0;
                lat[i]   = -1;
            end else if (valid[i] && n[i] < 100000) begin
                n[i]++;
            end
        end
    end

    always @(negedge clk) begin
        int ea, eb, ed, ep, ee, es;
        if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                model_out(hold_of(i), md_r[i], valid[i], n[i], ea, eb, ed, ep, ee, es);
                check($sformatf("i%0d a", i),         32'(a_o[i]),    32'(ea));
                check($sformatf("i%0d busy", i),      32'(busy_o[i]), 32'(eb));
                check($sformatf("i%0d done", i),      32'(done_o[i]), 32'(ed));
                check($sformatf("i%0d pass", i),      32'(pass_o[i]), 32'(ep));
                check($sformatf("i%0d err_count", i), 32'(err_o[i]),  32'(ee));
                check($sformatf("i%0d sum_total", i), 32'(tot_o[i]),  32'(es));
                if (valid[i] && done_o[i] === 1'b1) begin
                    dcnt[i]++;
                    if (!seen[i]) lat[i] = cyc - e0[i];
                    seen[i] = 1'b1;
                end
            end
        end
    end

    task automatic pulse(input bit p0, input bit p1, input bit p2, input bit p3);
        start_v[0] = p0; start_v[1] = p1; start_v[2] = p2; start_v[3] = p3;
        @(negedge clk);
        for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " a"},    32'(a_o[0]),    0);
        check({tag, " busy"}, 32'(busy_o[0]), 0);
        check({tag, " done"}, 32'(done_o[0]), 0);
        check({tag, " pass"}, 32'(pass_o[0]), 0);
        check({tag, " err"},  32'(err_o[0]),  0);
        check({tag, " sum"},  32'(tot_o[0]),  0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0;
            valid[i]   = 1'b0;
            n[i]       = 0;
            md_r[i]    = 0;
            lat[i]     = -1;
            dcnt[i]    = 0;
        end
        mode[0] = 0; mode[1] = 1; mode[2] = 0; mode[3] = 0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Sweep all instances; re-pulse start on the H=2 ones mid-run.
        pulse(1, 1, 1, 1);
        repeat (9) @(negedge clk);
        pulse(1, 0, 0, 1);
        repeat (70) @(negedge clk);
        check("h2 err_count", 32'(err_o[0]), 0);
        check("h2 sum_total", 32'(tot_o[0]), 48);
        check("h2 pass",      32'(pass_o[0]), 1);
        check("h2 done latency", 32'(lat[0]), 32);
        check("h2 done pulses",  32'(dcnt[0]), 1);
        check("h4 stuck0 err_count", 32'(err_o[1]), 15);
        check("h4 stuck0 sum_total", 32'(tot_o[1]), 0);
        check("h4 stuck0 pass",      32'(pass_o[1]), 0);
        check("h4 done latency",     32'(lat[1]), 64);
        check("h1 sum_total",        32'(tot_o[2]), 48);
        check("h1 pass",             32'(pass_o[2]), 1);
        check("h1 done latency",     32'(lat[2]), 16);
        check("top sum_total",       32'(tot_o[3]), 48);
        check("top pass",            32'(pass_o[3]), 1);

        // Sum stuck at 7: every sample mismatches and the total wraps 112 -> 48.
        mode[2] = 2;
        pulse(0, 0, 1, 0);
        repeat (25) @(negedge clk);
        check("h1 stuck7 err_count", 32'(err_o[2]), 16);
        check("h1 stuck7 sum_total", 32'(tot_o[2]), 48);
        check("h1 stuck7 pass",      32'(pass_o[2]), 0);
        mode[2] = 0;

        // Reset while a=5, then restart two cycles later.
        pulse(1, 0, 0, 0);
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            if (a_o[0] == 4'd5) found = 1'b1;
            else @(negedge clk);
        end
        check("h2 reaches a=5", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        @(negedge clk);
        pulse(1, 0, 0, 0);
        repeat (40) @(negedge clk);
        check("restart sum_total", 32'(tot_o[0]), 48);
        check("restart pass",      32'(pass_o[0]), 1);
        check("restart latency",   32'(lat[0]), 32);

        // rst and start together: reset wins.
        rst = 1'b1;
        for (int i = 0; i < NI; i++) start_v[i] = 1'b1;
        @(negedge clk);
        check("rst+start busy", 32'(busy_o[0]), 0);
        check("rst+start a",    32'(a_o[0]), 0);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst+start stays idle", 32'(busy_o[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
